// File: rtl/ztex_fifo_pkg.sv
// Shared definitions for the FX2 slave-FIFO traffic blocks (IN and OUT side):
// FSM state encoding, FIFOADR endpoint codes and the FD bus width.
package ztex_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    READ  = 2'd2,
    WAIT  = 2'd3
  } fifo_state_t;

  localparam logic [1:0] EP2 = 2'b00;
  localparam logic [1:0] EP4 = 2'b01;
  localparam logic [1:0] EP6 = 2'b10;
  localparam logic [1:0] EP8 = 2'b11;

  localparam int BUS_W = 16;

endpackage

// File: rtl/outtraffic_if.sv
// FX2 synchronous slave-FIFO pin bundle.
// master = FPGA side (drives the strobes), slave = FX2 side (drives FD/FLAGA).
interface outtraffic_if;
  import ztex_fifo_pkg::*;

  logic [BUS_W-1:0] FD;
  logic             FLAGA;
  logic             SLOE;
  logic             SLRD;
  logic             SLWR;
  logic             PKTEND;
  logic             FIFOADR0;
  logic             FIFOADR1;

  modport master (
    input  FD, FLAGA,
    output SLOE, SLRD, SLWR, PKTEND, FIFOADR0, FIFOADR1
  );

  modport slave (
    output FD, FLAGA,
    input  SLOE, SLRD, SLWR, PKTEND, FIFOADR0, FIFOADR1
  );

endinterface

// File: rtl/outtraffic_pattern_checker.sv
// Incrementing-pattern checker for the OUT traffic stream.
// Built only when OUTTRAFFIC_CHECK_EN is defined.
// The first valid word seeds the expected value; every later word is compared
// against it, and a mismatch bumps a saturating error count and resyncs.
`ifdef OUTTRAFFIC_CHECK_EN
module pattern_checker
  import ztex_fifo_pkg::*;
#(
  parameter int ERR_W = 16
) (
  input  logic             IFCLK,
  input  logic             RESET_N,
  input  logic             valid,
  input  logic [BUS_W-1:0] word,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             LOCKED
);

  logic [BUS_W-1:0] expected;

  // Seed on the first word, then compare/resync on every valid word.
  always_ff @(posedge IFCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      expected <= '0;
      ERR_CNT  <= '0;
      LOCKED   <= 1'b0;
    end else if (valid) begin
      // Next expected is always word+1: equal to expected+1 on a match,
      // and the resync value on a mismatch. Wraps FFFF -> 0000 naturally.
      expected <= word + BUS_W'(1);
      LOCKED   <= 1'b1;
      if (LOCKED && (word != expected) && (ERR_CNT != '1))
        ERR_CNT <= ERR_CNT + ERR_W'(1);
    end
  end

endmodule
`endif

// File: rtl/outtraffic.sv
// OUT-traffic sink: drains FX2 EP2 via the synchronous slave FIFO on IFCLK,
// counts received words and (optionally) checks for an incrementing pattern.
// Optional feature macro: OUTTRAFFIC_CHECK_EN (pattern checker, ERR_CNT, LOCKED).
//
// state | meaning
// IDLE  | bus released, SLOE=1, FIFOADR=0, waiting for CS
// SETUP | one cycle with FIFOADR/SLOE driven so the bus settles
// READ  | strobing SLRD whenever FLAGA shows data and CS is held
// WAIT  | FIFO empty, bus kept, waiting for FLAGA
module outtraffic
  import ztex_fifo_pkg::*;
#(
  parameter logic [1:0] FIFO_ADDR = EP2,
  parameter int         ERR_W     = 16
) (
  input  logic             IFCLK,
  input  logic             RESET_N,
  input  logic             CS,
  outtraffic_if.master     fx2,
  output logic [31:0]      WORD_CNT,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             LOCKED
);

  fifo_state_t state;
  logic        sloe_q;
  logic [1:0]  adr_q;
  logic        rd_strobe;
  logic        acc_q;

  // Strobe is combinational on CS and FLAGA so an empty flag or CS drop
  // suppresses the read in the same cycle (no underflow, no lost word).
  assign rd_strobe    = (state == READ) && CS && fx2.FLAGA;
  assign fx2.SLRD     = ~rd_strobe;
  assign fx2.SLOE     = sloe_q;
  assign fx2.FIFOADR0 = adr_q[0];
  assign fx2.FIFOADR1 = adr_q[1];
  assign fx2.SLWR     = 1'b1;
  assign fx2.PKTEND   = 1'b1;

  // Sequencing FSM with registered bus-ownership outputs.
  always_ff @(posedge IFCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= IDLE;
      sloe_q <= 1'b1;
      adr_q  <= 2'b00;
    end else if (!CS) begin
      state  <= IDLE;
      sloe_q <= 1'b1;
      adr_q  <= 2'b00;
    end else begin
      sloe_q <= 1'b0;
      adr_q  <= FIFO_ADDR;
      case (state)
        IDLE:    state <= SETUP;
        SETUP:   state <= READ;
        READ:    state <= fx2.FLAGA ? READ : WAIT;
        WAIT:    state <= fx2.FLAGA ? READ : WAIT;
        default: state <= IDLE;
      endcase
    end
  end

  // Acceptance flag pipelined one cycle so WORD_CNT lines up with the checker.
  always_ff @(posedge IFCLK or negedge RESET_N) begin
    if (!RESET_N) acc_q <= 1'b0;
    else          acc_q <= rd_strobe;
  end

  // Word counter, wraps modulo 2^32; CS does not clear it.
  always_ff @(posedge IFCLK or negedge RESET_N) begin
    if (!RESET_N)   WORD_CNT <= '0;
    else if (acc_q) WORD_CNT <= WORD_CNT + 32'd1;
  end

`ifdef OUTTRAFFIC_CHECK_EN
  logic [BUS_W-1:0] fd_q;

  // Register the accepted word for the checker.
  always_ff @(posedge IFCLK or negedge RESET_N) begin
    if (!RESET_N)       fd_q <= '0;
    else if (rd_strobe) fd_q <= fx2.FD;
  end

  pattern_checker #(
    .ERR_W (ERR_W)
  ) u_chk (
    .IFCLK   (IFCLK),
    .RESET_N (RESET_N),
    .valid   (acc_q),
    .word    (fd_q),
    .ERR_CNT (ERR_CNT),
    .LOCKED  (LOCKED)
  );
`else
  // Without the checker the data bus content is irrelevant; only strobes count.
  logic unused_fd;
  assign unused_fd = ^fx2.FD;
  assign ERR_CNT   = '0;
  assign LOCKED    = 1'b0;
`endif

endmodule
